// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding,
// parity-mode constants and a constant-function log2 for counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned w;
    r = 0;
    w = 1;
    while (w < v) begin
      w = w << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop rx synchroniser; with UART_RX_MAJORITY_VOTE_EN defined it also
// votes 2-of-3 over the samples at ticks OVS/2-2, OVS/2-1 and OVS/2.
module uart_rx_sync #(
  parameter int unsigned OVS = 16,
  parameter int unsigned SW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [SW-1:0] s_reg,
  output logic          sample
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= rx;
      r_sync <= r_meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [SW-1:0] MID = SW'(OVS / 2);

  logic r_v0;
  logic r_v1;
  logic r_vote;
  logic w_maj;

  assign w_maj = (r_v0 & r_v1) | (r_v0 & r_sync) | (r_v1 & r_sync);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0   <= 1'b1;
      r_v1   <= 1'b1;
      r_vote <= 1'b1;
    end else if (s_tick) begin
      if (s_reg == MID - SW'(2)) r_v0 <= r_sync;
      if (s_reg == MID - SW'(1)) r_v1 <= r_sync;
      if (s_reg == MID)          r_vote <= w_maj;
    end
  end

  // Before mid-bit (incl. IDLE) the raw line is used; after it, the held vote.
  assign sample = (s_reg == MID) ? w_maj : ((s_reg > MID) ? r_vote : r_sync);
`else
  logic unused_vote_inputs;
  assign unused_vote_inputs = ^{s_tick, s_reg};
  assign sample = r_sync;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity, error flags and valid/ready output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 mid-bit voting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVS        = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rx_ready,
  output logic            rx_valid,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            busy
);

  localparam int unsigned SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned SW   = clog2(SMAX);
  localparam int unsigned NW   = clog2(DBIT);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [SW-1:0] START_CHK = SW'(OVS / 2);
`else
  localparam logic [SW-1:0] START_CHK = SW'(OVS / 2 - 1);
`endif
  localparam logic [SW-1:0] BIT_END  = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  localparam bit            PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_e          r_state, w_state_nx;
  logic [SW-1:0]   r_s, w_s_nx;
  logic [NW-1:0]   r_n, w_n_nx;
  logic [DBIT-1:0] r_b, w_b_nx;
  logic            r_par, w_par_nx;
  logic            w_sample;
  logic            w_done;
  logic            w_perr;

  logic            r_valid;
  logic [DBIT-1:0] r_dout;
  logic            r_perr;
  logic            r_ferr;
  logic            r_ovr;

  uart_rx_sync #(
    .OVS (OVS),
    .SW  (SW)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .s_reg  (r_s),
    .sample (w_sample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_par   <= w_par_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_par_nx   = r_par;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_sample) begin
          w_state_nx = START;
          w_s_nx     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == START_CHK) begin
            w_s_nx = '0;
            w_n_nx = '0;
            // Line back high at mid start bit: glitch, not a frame.
            w_state_nx = w_sample ? IDLE : DATA;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == BIT_END) begin
            w_b_nx = {w_sample, r_b[DBIT-1:1]};
            w_s_nx = '0;
            if (r_n == N_LAST) begin
              w_n_nx     = '0;
              w_state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              w_n_nx = r_n + 1'b1;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (r_s == BIT_END) begin
            w_par_nx   = w_sample;
            w_s_nx     = '0;
            w_state_nx = STOP;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == STOP_END) begin
            w_done     = 1'b1;
            w_s_nx     = '0;
            w_state_nx = IDLE;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_perr = (PARITY_EN != 0) && ((^r_b) ^ r_par ^ PAR_MODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || rx_ready)) begin
        r_valid <= 1'b1;
        r_dout  <= r_b;
        r_perr  <= w_perr;
        r_ferr  <= ~w_sample;
      end else begin
        // A completion here means the old word is still pending: drop the new one.
        if (w_done) r_ovr <= 1'b1;
        if (r_valid && rx_ready) r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid    = r_valid;
  assign dout        = r_dout;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (A) and an 8E1 instance (B) fed
// from bit-level serial stimulus, with a queue of expected words.
module tb_uart_rx_param;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick
  localparam int TIMEOUT = 3000;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic       val_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       val_b, perr_b, ferr_b, ovr_b, busy_b;
  logic [7:0] dout_a, dout_b;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ovr_cnt_a = 0;
  exp_t exp_q[$];

  uart_rx_param #(
    .DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick), .rx_ready(rdy_a),
    .rx_valid(val_a), .dout(dout_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(
    .DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick), .rx_ready(rdy_b),
    .rx_valid(val_b), .dout(dout_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun_err(ovr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int tcnt;
    tcnt   = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tcnt   = tcnt + 1;
      s_tick = (tcnt % 4 == 0);
    end
  end

  always @(negedge clk) if (ovr_a === 1'b1) ovr_cnt_a = ovr_cnt_a + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want run completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic align_tick();
    @(negedge clk);
    while (s_tick !== 1'b1) @(negedge clk);
  endtask

  task automatic accept(input bit sel);
    if (sel) rdy_b = 1'b1;
    else     rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  // sel=1 targets B (even parity bit after data).
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                            input logic stop, input int stop_len, input bit expect_word);
    exp_t e;
    if (expect_word) begin
      e.d  = d;
      e.pe = sel & ((^d) ^ par);
      e.fe = ~stop;
      exp_q.push_back(e);
    end
    drive_rx(sel, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, d[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    if (sel) begin
      drive_rx(sel, par);
      repeat (BIT_CLK) @(negedge clk);
    end
    drive_rx(sel, stop);
    repeat (stop_len) @(negedge clk);
    drive_rx(sel, 1'b1);
  endtask

  // lat_ok: previous clk had an s_tick while busy, and busy dropped with rx_valid.
  task automatic wait_valid(input bit sel, output bit found, output bit lat_ok, output int vcyc);
    bit pt, pb;
    found = 1'b0; lat_ok = 1'b0; vcyc = 0; pt = 1'b0; pb = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if ((sel ? val_b : val_a) === 1'b1) begin
        found  = 1'b1;
        vcyc   = cyc;
        lat_ok = pt && pb && ((sel ? busy_b : busy_a) === 1'b0);
        break;
      end
      pt = s_tick;
      pb = sel ? busy_b : busy_a;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({val_a, dout_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
      errors++;
      $display("FAIL reset_a: got %h, want 0", {val_a, dout_a, perr_a, ferr_a, ovr_a, busy_a});
    end
    checks++;
    if ({val_b, dout_b, perr_b, ferr_b, ovr_b, busy_b} !== 13'h0) begin
      errors++;
      $display("FAIL reset_b: got %h, want 0", {val_b, dout_b, perr_b, ferr_b, ovr_b, busy_b});
    end
  endtask

  task automatic test_basic();
    exp_t e;
    bit found, lat;
    int vc;
    align_tick();
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, found, lat, vc);
    join
    e = exp_q.pop_front();
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, want 1", found); end
    checks++;
    if (lat !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b, want 1", lat); end
    repeat (8) @(negedge clk);
    checks++;
    if (val_a !== 1'b1 || dout_a !== e.d) begin
      errors++;
      $display("FAIL basic_dout: got v=%b d=%h, want v=1 d=%h", val_a, dout_a, e.d);
    end
    checks++;
    if ({perr_a, ferr_a} !== {e.pe, e.fe}) begin
      errors++;
      $display("FAIL basic_flags: got %b, want %b", {perr_a, ferr_a}, {e.pe, e.fe});
    end
    accept(1'b0);
    checks++;
    if (val_a !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b, want 0", val_a); end
  endtask

  task automatic test_parity();
    logic [8:0] tbl [3];
    exp_t e;
    bit found, lat;
    int vc;
    tbl = '{{1'b1, 8'hA3}, {1'b1, 8'h07}, {1'b1, 8'h5A}};
    for (int k = 0; k < 3; k++) begin
      align_tick();
      fork
        send_frame(1'b1, tbl[k][7:0], tbl[k][8], 1'b1, BIT_CLK, 1'b1);
        wait_valid(1'b1, found, lat, vc);
      join
      e = exp_q.pop_front();
      checks++;
      if (found !== 1'b1 || dout_b !== e.d) begin
        errors++;
        $display("FAIL parity_dout[%0d]: got v=%b d=%h, want v=1 d=%h", k, found, dout_b, e.d);
      end
      checks++;
      if ({perr_b, ferr_b} !== {e.pe, e.fe}) begin
        errors++;
        $display("FAIL parity_flags[%0d]: got %b, want %b", k, {perr_b, ferr_b}, {e.pe, e.fe});
      end
      accept(1'b1);
    end
  endtask

  task automatic test_false_start();
    bit busy_seen, val_seen;
    busy_seen = 1'b0; val_seen = 1'b0;
    align_tick();
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    for (int i = 0; i < 3 * BIT_CLK; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) busy_seen = 1'b1;
      if (val_a === 1'b1) val_seen = 1'b1;
    end
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got 0, want 1"); end
    checks++;
    if (val_seen !== 1'b0) begin errors++; $display("FAIL glitch_no_word: got 1, want 0"); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b, want 0", busy_a); end
  endtask

  task automatic test_frame_err();
    exp_t e;
    bit found, lat;
    int vc;
    align_tick();
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 48, 1'b1);
      wait_valid(1'b0, found, lat, vc);
    join
    e = exp_q.pop_front();
    checks++;
    if (found !== 1'b1 || dout_a !== e.d || ferr_a !== e.fe || perr_a !== e.pe) begin
      errors++;
      $display("FAIL frame_err: got v=%b d=%h f=%b p=%b, want v=1 d=%h f=%b p=%b",
               found, dout_a, ferr_a, perr_a, e.d, e.fe, e.pe);
    end
    accept(1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++;
    if (val_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_recover: got v=%b busy=%b, want 0 0", val_a, busy_a);
    end
    align_tick();
    fork
      send_frame(1'b0, 8'h81, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, found, lat, vc);
    join
    e = exp_q.pop_front();
    checks++;
    if (found !== 1'b1 || dout_a !== e.d || ferr_a !== e.fe) begin
      errors++;
      $display("FAIL frame_next: got v=%b d=%h f=%b, want v=1 d=%h f=%b",
               found, dout_a, ferr_a, e.d, e.fe);
    end
    accept(1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit found, lat;
    int vc, c0, off, ov0;
    align_tick();
    c0 = cyc;
    fork
      send_frame(1'b0, 8'h11, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, found, lat, vc);
    join
    off = vc - c0;
    e = exp_q.pop_front();
    checks++;
    if (found !== 1'b1 || dout_a !== e.d) begin
      errors++;
      $display("FAIL b2b_first: got v=%b d=%h, want v=1 d=%h", found, dout_a, e.d);
    end
    ov0 = ovr_cnt_a;
    align_tick();
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, BIT_CLK, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ovr_cnt_a - ov0 !== 1) begin
      errors++;
      $display("FAIL b2b_overrun_count: got %0d, want 1", ovr_cnt_a - ov0);
    end
    checks++;
    if (val_a !== 1'b1 || dout_a !== e.d) begin
      errors++;
      $display("FAIL b2b_kept: got v=%b d=%h, want v=1 d=%h", val_a, dout_a, e.d);
    end
    // Accept exactly in the completion clk of the next frame.
    ov0 = ovr_cnt_a;
    align_tick();
    c0 = cyc;
    fork
      send_frame(1'b0, 8'h22, 1'b0, 1'b1, BIT_CLK, 1'b1);
      begin
        while (cyc < c0 + off - 1) @(negedge clk);
        rdy_a = 1'b1;
        checks++;
        if (val_a !== 1'b1 || dout_a !== 8'h11) begin
          errors++;
          $display("FAIL b2b_pre_accept: got v=%b d=%h, want v=1 d=11", val_a, dout_a);
        end
        @(negedge clk);
        rdy_a = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (val_a !== 1'b1 || dout_a !== e.d) begin
          errors++;
          $display("FAIL b2b_simul_load: got v=%b d=%h, want v=1 d=%h", val_a, dout_a, e.d);
        end
      end
    join
    repeat (4) @(negedge clk);
    checks++;
    if (ovr_cnt_a !== ov0) begin
      errors++;
      $display("FAIL b2b_simul_no_overrun: got %0d, want %0d", ovr_cnt_a, ov0);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit found, lat;
    int vc;
    align_tick();
    fork
      send_frame(1'b0, 8'hF0, 1'b0, 1'b1, BIT_CLK, 1'b0);
      begin
        repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b, want 1", busy_a); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({val_a, dout_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
          errors++;
          $display("FAIL rst_mid_outputs: got %h, want 0",
                   {val_a, dout_a, perr_a, ferr_a, ovr_a, busy_a});
        end
      end
    join
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (val_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_discard: got v=%b busy=%b, want 0 0", val_a, busy_a);
    end
    align_tick();
    fork
      send_frame(1'b0, 8'hF0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, found, lat, vc);
    join
    e = exp_q.pop_front();
    checks++;
    if (found !== 1'b1 || dout_a !== e.d || ferr_a !== e.fe) begin
      errors++;
      $display("FAIL rst_mid_next: got v=%b d=%h f=%b, want v=1 d=%h f=%b",
               found, dout_a, ferr_a, e.d, e.fe);
    end
    accept(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
